// File: rtl/isram_arb_pkg.sv
// Shared types and default sizing for the ISRAM host/corelet arbiter.
package isram_arb_pkg;

  localparam int AW_DEF         = 7;
  localparam int DW_DEF         = 32;
  localparam int STARVE_MAX_DEF = 8;

  // Which requester, and which kind of access, owns the SRAM read-data
  // slot in the cycle after a grant.
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    CORE_RD = 2'd1,
    HOST_RD = 2'd2,
    HOST_WR = 2'd3
  } owner_t;

endpackage

// File: rtl/arb_starve_ctr.sv
// Counts consecutive cycles in which the host asks but is denied, and
// raises o_force once the host has waited STARVE_MAX-1 cycles.
module arb_starve_ctr
  import isram_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force
);

  localparam int            CW  = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CW-1:0] SAT = CW'(STARVE_MAX - 1);

  logic [CW-1:0] r_cnt;

  // Denied-cycle counter: clears on grant or idle, saturates at SAT.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_force = i_req && (r_cnt == SAT);

endmodule

// File: rtl/isram_arb.sv
// Single-port ISRAM arbiter: the corelet has fixed priority, the host loader
// gets a forced grant after STARVE_MAX-1 denied cycles. Grant and SRAM pins
// are combinational in the request cycle; read data returns one cycle later.
module isram_arb
  import isram_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  // host loader
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata,
  // corelet
  input  logic          c_req,
  input  logic [AW-1:0] c_addr,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  // ISRAM macro
  output logic [AW-1:0] I_A,
  output logic [DW-1:0] I_D,
  output logic          I_CEN,
  output logic          I_WEN,
  input  logic [DW-1:0] I_Q,
  output logic          starve_evt
);

  logic   w_force;
  logic   w_c_gnt;
  logic   w_h_gnt;
  owner_t r_owner;
  owner_t w_owner_nxt;

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk     (clk),
    .reset_n (reset_n),
    .i_req   (h_req),
    .i_gnt   (w_h_gnt),
    .o_force (w_force)
  );

  // Grants are gated by reset_n so nothing reaches the SRAM while in reset.
  assign w_c_gnt    = reset_n && c_req && !w_force;
  assign w_h_gnt    = reset_n && h_req && (!c_req || w_force);
  assign c_gnt      = w_c_gnt;
  assign h_gnt      = w_h_gnt;
  assign starve_evt = reset_n && w_force;

  // Drive SRAM pins from this cycle's winner; idle pins are parked at
  // CEN/WEN high and address/data zero.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    I_CEN = 1'b1;
    I_WEN = 1'b1;
    I_A   = '0;
    I_D   = '0;
    if (w_c_gnt) begin
      I_CEN = 1'b0;
      I_A   = c_addr;
    end else if (w_h_gnt) begin
      I_CEN = 1'b0;
      I_A   = h_addr;
      if (h_we) begin
        I_WEN = 1'b0;
        I_D   = h_wdata;
      end
    end
  end

  // Classify this cycle's grant so the next cycle knows who gets I_Q.
  always_comb begin
    w_owner_nxt = NONE;
    if (w_c_gnt) begin
      w_owner_nxt = CORE_RD;
    end else if (w_h_gnt) begin
      w_owner_nxt = h_we ? HOST_WR : HOST_RD;
    end
  end

  // Owner register; an asynchronous reset drops any pending read return.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner <= NONE;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  assign c_rvalid = (r_owner == CORE_RD);
  assign h_rvalid = (r_owner == HOST_RD);
  assign c_rdata  = c_rvalid ? I_Q : '0;
  assign h_rdata  = h_rvalid ? I_Q : '0;

endmodule

// File: tb/tb_isram_arb.sv
// Directed bench for isram_arb with a behavioural one-cycle-latency SRAM.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_isram_arb;
  import isram_arb_pkg::*;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk;
  logic          reset_n;
  logic          h_req;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic          h_gnt;
  logic          h_rvalid;
  logic [DW-1:0] h_rdata;
  logic          c_req;
  logic [AW-1:0] c_addr;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic [AW-1:0] I_A;
  logic [DW-1:0] I_D;
  logic          I_CEN;
  logic          I_WEN;
  logic [DW-1:0] I_Q;
  logic          starve_evt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  isram_arb #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .h_req      (h_req),
    .h_we       (h_we),
    .h_addr     (h_addr),
    .h_wdata    (h_wdata),
    .h_gnt      (h_gnt),
    .h_rvalid   (h_rvalid),
    .h_rdata    (h_rdata),
    .c_req      (c_req),
    .c_addr     (c_addr),
    .c_gnt      (c_gnt),
    .c_rvalid   (c_rvalid),
    .c_rdata    (c_rdata),
    .I_A        (I_A),
    .I_D        (I_D),
    .I_CEN      (I_CEN),
    .I_WEN      (I_WEN),
    .I_Q        (I_Q),
    .starve_evt (starve_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous write, registered read data next cycle.
  always @(posedge clk) begin
    if (!I_CEN) begin
      if (!I_WEN) mem[I_A] <= I_D;
      else        I_Q      <= mem[I_A];
    end
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hA000_0000 | DW'(a);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = init_word(i);
    I_Q     = '0;
    reset_n = 1'b0;
    h_req   = 1'b1;
    h_we    = 1'b1;
    h_addr  = 7'd4;
    h_wdata = 32'h1234_5678;
    c_req   = 1'b1;
    c_addr  = 7'd3;

    // Reset holds everything quiet even with both requests active.
    @(negedge clk); #1;
    check("rst_c_gnt", c_gnt, 0);
    check("rst_h_gnt", h_gnt, 0);
    check("rst_cen",   I_CEN, 1);
    check("rst_wen",   I_WEN, 1);
    check("rst_a",     I_A, 0);
    check("rst_d",     I_D, 0);
    check("rst_evt",   starve_evt, 0);
    check("rst_c_rv",  c_rvalid, 0);
    check("rst_h_rv",  h_rvalid, 0);
    check("rst_c_rd",  c_rdata, 0);
    check("rst_owner", dut.r_owner, NONE);
    check("rst_cnt",   dut.u_starve.r_cnt, 0);

    // Host write then read of address 5; first grant right after release.
    reset_n = 1'b1;
    c_req   = 1'b0;
    h_req   = 1'b1;
    h_we    = 1'b1;
    h_addr  = 7'd5;
    h_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_h_gnt", h_gnt, 1);
    check("wr_cen",   I_CEN, 0);
    check("wr_wen",   I_WEN, 0);
    check("wr_a",     I_A, 5);
    check("wr_d",     I_D, 32'hDEAD_BEEF);
    check("wr_c_gnt", c_gnt, 0);

    @(negedge clk);
    h_we = 1'b0;
    #1;
    check("rd_h_gnt", h_gnt, 1);
    check("rd_wen",   I_WEN, 1);
    check("rd_a",     I_A, 5);
    check("wr_no_rv", h_rvalid, 0);

    @(negedge clk);
    h_req = 1'b0;
    #1;
    check("rd_h_rv",   h_rvalid, 1);
    check("rd_h_data", h_rdata, 32'hDEAD_BEEF);
    check("rd_c_rv",   c_rvalid, 0);
    check("idle_cen",  I_CEN, 1);
    check("idle_wen",  I_WEN, 1);
    check("idle_a",    I_A, 0);
    check("idle_d",    I_D, 0);

    // Corelet burst 72..87, one read per cycle.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c_req  = 1'b1;
      c_addr = AW'(72 + i);
      #1;
      check("burst_c_gnt", c_gnt, 1);
      check("burst_a",     I_A, 72 + i);
      if (i == 0) begin
        check("burst_rv0", c_rvalid, 0);
      end else begin
        check("burst_rv",   c_rvalid, 1);
        check("burst_data", c_rdata, init_word(72 + i - 1));
      end
    end
    @(negedge clk);
    c_req = 1'b0;
    #1;
    check("burst_rv_last",   c_rvalid, 1);
    check("burst_data_last", c_rdata, init_word(87));
    check("burst_h_rd",      h_rdata, 0);
    @(negedge clk); #1;
    check("burst_rv_end", c_rvalid, 0);
    check("burst_rd_end", c_rdata, 0);

    // Both requesting continuously: host forced every 8th cycle.
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      c_req  = 1'b1;
      c_addr = 7'd10;
      h_req  = 1'b1;
      h_we   = 1'b0;
      h_addr = 7'd9;
      #1;
      check("stv_h_gnt", h_gnt, (k % 8) == 0);
      check("stv_c_gnt", c_gnt, (k % 8) != 0);
      check("stv_evt",   starve_evt, (k % 8) == 0);
      check("stv_a",     I_A, ((k % 8) == 0) ? 9 : 10);
      check("stv_h_rv",  h_rvalid, (k > 1) && ((k - 1) % 8 == 0));
      check("stv_c_rv",  c_rvalid, (k > 1) && ((k - 1) % 8 != 0));
      if ((k > 1) && ((k - 1) % 8 == 0)) check("stv_h_data", h_rdata, init_word(9));
    end

    // Counter at 3 with both requesting: corelet wins, counter advances.
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); #1;
      check("pre_c_gnt", c_gnt, 1);
    end
    @(negedge clk); #1;
    check("cnt3",      dut.u_starve.r_cnt, 3);
    check("cnt3_cgnt", c_gnt, 1);
    check("cnt3_hgnt", h_gnt, 0);
    @(negedge clk);
    check("cnt4", dut.u_starve.r_cnt, 4);
    h_req = 1'b0;
    #1;
    @(negedge clk); #1;
    check("cnt_clr", dut.u_starve.r_cnt, 0);

    // Reset in the cycle after a corelet read grant discards rvalid.
    c_req  = 1'b1;
    c_addr = 7'd20;
    #1;
    check("mid_c_gnt", c_gnt, 1);
    @(negedge clk);
    reset_n = 1'b0;
    c_req   = 1'b0;
    #1;
    check("mid_c_rv",  c_rvalid, 0);
    check("mid_c_rd",  c_rdata, 0);
    check("mid_cen",   I_CEN, 1);
    check("mid_owner", dut.r_owner, NONE);
    @(negedge clk);
    reset_n = 1'b1;
    c_req   = 1'b1;
    c_addr  = 7'd21;
    #1;
    check("post_c_gnt", c_gnt, 1);
    @(negedge clk);
    c_req = 1'b0;
    #1;
    check("post_c_rv",   c_rvalid, 1);
    check("post_c_data", c_rdata, init_word(21));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
